seq_shift_add_mult: RTL and testbench

//  - Sequential unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, using the shift-and-add method.
//  - Each cycle adds one partial product into the accumulator, through a ripple-carry adder sub-block.
//  - Takes operands from the datapath register file and returns the product to the ALU result mux.
//  - Next stage after the 4-bit ripple-carry adder; the lab ALU uses it for MUL.
//

---
 rtl/seq_shift_add_mult_pkg.sv | 15 +
 rtl/seq_shift_add_mult_rca.sv | 25 ++
 rtl/seq_shift_add_mult.sv | 107 ++++++++++
 tb/tb_seq_shift_add_mult.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package seq_shift_add_mult_pkg;

    // Operand width used when the instantiating level does not override it.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states; encodings are fixed so they match the lab datapath docs.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_add_mult_rca.sv
// N-bit ripple-carry adder: a chain of full adders, carry rippling from bit 0
// upwards. Parameterized form of the 4-bit lab adder.
module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    // One full adder per bit; carry[i+1] is the majority of the three inputs.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned WIDTH x WIDTH multiplier using shift-and-add.
// One partial product is added per cycle through rca_n; the {A,Q} pair is
// then shifted right one place. The result is latched into product on the
// final step and held until the next accepted start.
import seq_shift_add_mult_pkg::*;

module seq_shift_add_mult #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t              state;
    state_t              state_nxt;

    // The carry bit A[WIDTH] is always zero after a shift (the adder carry
    // lands in A[WIDTH-1]), so only the low WIDTH bits of A are stored.
    logic [WIDTH-1:0]    m;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    q;
    logic [CW-1:0]       count;

    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    sum;
    logic                cout;
    logic                last_step;

    // Partial product selection: add the multiplicand only when Q[0] is set.
    always_comb begin
        addend    = q[0] ? m : '0;
        last_step = (count == CW'(WIDTH - 1));
    end

    rca_n #(.N(WIDTH)) u_rca (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last_step) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; busy/done are registered from the next state so they
    // have no combinational path from any input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Datapath: operand capture in IDLE, add-and-shift in CALC, result latch on the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                S_CALC: begin
                    acc   <= {cout, sum[WIDTH-1:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (last_step) begin
                        product <= {cout, sum, q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed self-checking bench for seq_shift_add_mult (WIDTH = 4).
module tb_seq_shift_add_mult;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands with start high; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Called #1 after the accepting edge. Expects done after exactly W more
    // edges, busy for W+1 sampled cycles, and a one-cycle done pulse.
    task automatic wait_done(input string tag, input logic [2*W-1:0] exp);
        int n     = 0;
        int busyc = 0;
        while (!done && n < 20) begin
            if (busy) busyc++;
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) busyc++;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy_cycles"}, 32'(busyc), 32'(W + 1));
        check({tag, "_product"}, 32'(product), 32'(exp));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_product_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 15 x 15
        launch(4'd15, 4'd15, 1'b0);
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_done("t1_15x15", 8'hE1);

        // 2: back-to-back runs
        launch(4'd10, 4'd3, 1'b0);
        wait_done("t2_10x3", 8'h1E);
        launch(4'd0, 4'd13, 1'b0);
        wait_done("t2_0x13", 8'h00);
        launch(4'd1, 4'd1, 1'b0);
        wait_done("t2_1x1", 8'h01);

        // 3: start held high, operands changed mid-run
        launch(4'd5, 4'd6, 1'b1);
        @(negedge clk);
        a = 4'd9;
        b = 4'd9;
        wait_done("t3_captured_5x6", 8'h1E);
        @(posedge clk);
        #1;
        check("t3_reaccept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("t3_second_9x9", 8'h51);

        // 4: reset on the 2nd CALC edge of a 9x7 run
        launch(4'd9, 4'd7, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t4_reset_busy", 32'(busy), 32'd0);
        check("t4_reset_done", 32'(done), 32'd0);
        check("t4_reset_product", 32'(product), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            check("t4_no_done_pulse", 32'(seen), 32'd0);
        end
        launch(4'd6, 4'd6, 1'b0);
        wait_done("t4_6x6", 8'h24);

        // 5: exhaustive against a*b
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                launch(W'(i), W'(j), 1'b0);
                wait_done($sformatf("t5_%0dx%0d", i, j), 8'(i * j));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
